// File: rtl/microcode_sequencer.sv
// SAP-1.5 control unit: T-state counter plus opcode/flag decode into one-cycle datapath strobes.
// Optional macro VARIABLE_LENGTH_EN: step returns to 0 right after each opcode's last active execute step.
module microcode_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEPS        = 7,
    parameter int STEP_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    input  logic                    flag_zero_i,
    input  logic                    flag_carry_i,
    input  logic                    flag_negative_i,
    output logic                    pc_inc_o,
    output logic                    pc_load_o,
    output logic                    pc_oe_o,
    output logic                    mar_load_o,
    output logic                    ram_oe_o,
    output logic                    ram_we_o,
    output logic                    ir_load_o,
    output logic                    ir_oe_o,
    output logic                    a_load_o,
    output logic                    a_oe_o,
    output logic                    b_load_o,
    output logic                    alu_oe_o,
    output logic                    alu_sub_o,
    output logic                    flags_load_o,
    output logic                    o_load_o,
    output logic                    halt_o,
    output logic [STEP_WIDTH-1:0]   step_o
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA  = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_STA  = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC   = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] OP_JN   = OPCODE_WIDTH'(4'h9);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUTA = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(4'hF);

    localparam logic [STEP_WIDTH-1:0] T0 = STEP_WIDTH'(0);
    localparam logic [STEP_WIDTH-1:0] T1 = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] T2 = STEP_WIDTH'(2);
    localparam logic [STEP_WIDTH-1:0] T3 = STEP_WIDTH'(3);
    localparam logic [STEP_WIDTH-1:0] T4 = STEP_WIDTH'(4);

    state_t                  state_q, state_d;
    logic [STEP_WIDTH-1:0]   step_q, step_d;
    logic                    wrap_step;

`ifdef VARIABLE_LENGTH_EN
    logic [STEP_WIDTH-1:0]   last_exec;

    // Opcode is only meaningful from T2, so the early wrap is gated on that.
    always_comb begin
        last_exec = T2;
        case (opcode_i)
            OP_LDA, OP_STA: last_exec = T3;
            OP_ADD, OP_SUB: last_exec = T4;
            default:        last_exec = T2;
        endcase
    end

    assign wrap_step = (step_q >= T2) && (step_q == last_exec);
`else
    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(STEPS - 1);

    assign wrap_step = (step_q == LAST_STEP);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        pc_inc_o     = 1'b0;
        pc_load_o    = 1'b0;
        pc_oe_o      = 1'b0;
        mar_load_o   = 1'b0;
        ram_oe_o     = 1'b0;
        ram_we_o     = 1'b0;
        ir_load_o    = 1'b0;
        ir_oe_o      = 1'b0;
        a_load_o     = 1'b0;
        a_oe_o       = 1'b0;
        b_load_o     = 1'b0;
        alu_oe_o     = 1'b0;
        alu_sub_o    = 1'b0;
        flags_load_o = 1'b0;
        o_load_o     = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
                step_d  = '0;
            end
            ST_RUN: begin
                step_d = wrap_step ? '0 : step_q + STEP_WIDTH'(1);
                if (step_q == T0) begin
                    pc_oe_o    = 1'b1;
                    mar_load_o = 1'b1;
                end else if (step_q == T1) begin
                    ram_oe_o  = 1'b1;
                    ir_load_o = 1'b1;
                    pc_inc_o  = 1'b1;
                end else begin
                    case (opcode_i)
                        OP_LDA: begin
                            if (step_q == T2) begin
                                ir_oe_o    = 1'b1;
                                mar_load_o = 1'b1;
                            end else if (step_q == T3) begin
                                ram_oe_o     = 1'b1;
                                a_load_o     = 1'b1;
                                flags_load_o = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (step_q == T2) begin
                                ir_oe_o    = 1'b1;
                                mar_load_o = 1'b1;
                            end else if (step_q == T3) begin
                                ram_oe_o  = 1'b1;
                                b_load_o  = 1'b1;
                                alu_sub_o = (opcode_i == OP_SUB);
                            end else if (step_q == T4) begin
                                alu_oe_o     = 1'b1;
                                a_load_o     = 1'b1;
                                flags_load_o = 1'b1;
                                alu_sub_o    = (opcode_i == OP_SUB);
                            end
                        end
                        OP_STA: begin
                            if (step_q == T2) begin
                                ir_oe_o    = 1'b1;
                                mar_load_o = 1'b1;
                            end else if (step_q == T3) begin
                                a_oe_o   = 1'b1;
                                ram_we_o = 1'b1;
                            end
                        end
                        OP_LDI: begin
                            if (step_q == T2) begin
                                ir_oe_o      = 1'b1;
                                a_load_o     = 1'b1;
                                flags_load_o = 1'b1;
                            end
                        end
                        OP_JMP, OP_JC, OP_JZ, OP_JN: begin
                            // Conditional jumps use the flag register value as held during T2.
                            if ((step_q == T2) &&
                                ((opcode_i == OP_JMP) ||
                                 ((opcode_i == OP_JC) && flag_carry_i) ||
                                 ((opcode_i == OP_JZ) && flag_zero_i) ||
                                 ((opcode_i == OP_JN) && flag_negative_i))) begin
                                ir_oe_o   = 1'b1;
                                pc_load_o = 1'b1;
                            end
                        end
                        OP_OUTA: begin
                            if (step_q == T2) begin
                                a_oe_o   = 1'b1;
                                o_load_o = 1'b1;
                            end
                        end
                        OP_HLT: begin
                            if (step_q == T2) begin
                                state_d = ST_HALT;
                                step_d  = step_q;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: ;
            default: begin
                state_d = ST_INIT;
                step_d  = '0;
            end
        endcase
    end

    assign halt_o = (state_q == ST_HALT);
    assign step_o = step_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomized scoreboard bench for microcode_sequencer: driver queues expected per-cycle strobes, monitor checks them.
// Honours VARIABLE_LENGTH_EN the same way as the design when building expected instruction lengths.
module tb_microcode_sequencer;

    localparam logic [14:0] PC_INC   = 15'h4000;
    localparam logic [14:0] PC_LD    = 15'h2000;
    localparam logic [14:0] PC_OE    = 15'h1000;
    localparam logic [14:0] MAR_LD   = 15'h0800;
    localparam logic [14:0] RAM_OE   = 15'h0400;
    localparam logic [14:0] RAM_WE   = 15'h0200;
    localparam logic [14:0] IR_LD    = 15'h0100;
    localparam logic [14:0] IR_OE    = 15'h0080;
    localparam logic [14:0] A_LD     = 15'h0040;
    localparam logic [14:0] A_OE     = 15'h0020;
    localparam logic [14:0] B_LD     = 15'h0010;
    localparam logic [14:0] ALU_OE   = 15'h0008;
    localparam logic [14:0] ALU_SUB  = 15'h0004;
    localparam logic [14:0] FL_LD    = 15'h0002;
    localparam logic [14:0] O_LD     = 15'h0001;
    localparam logic [14:0] OE_MASK  = PC_OE | RAM_OE | IR_OE | A_OE | ALU_OE;

    typedef struct {
        logic [14:0] strb;
        logic        halt;
        logic        chk_step;
        logic [2:0]  step;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        fz = 1'b0, fc = 1'b0, fn = 1'b0;
    logic        pc_inc, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe;
    logic        a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, o_load, halt;
    logic [2:0]  step;
    logic [14:0] act_strb;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    bit   driver_done = 1'b0;

    always #5 clk = ~clk;

    microcode_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .opcode_i        (opcode),
        .flag_zero_i     (fz),
        .flag_carry_i    (fc),
        .flag_negative_i (fn),
        .pc_inc_o        (pc_inc),
        .pc_load_o       (pc_load),
        .pc_oe_o         (pc_oe),
        .mar_load_o      (mar_load),
        .ram_oe_o        (ram_oe),
        .ram_we_o        (ram_we),
        .ir_load_o       (ir_load),
        .ir_oe_o         (ir_oe),
        .a_load_o        (a_load),
        .a_oe_o          (a_oe),
        .b_load_o        (b_load),
        .alu_oe_o        (alu_oe),
        .alu_sub_o       (alu_sub),
        .flags_load_o    (flags_load),
        .o_load_o        (o_load),
        .halt_o          (halt),
        .step_o          (step)
    );

    assign act_strb = {pc_inc, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe,
                       a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, o_load};

    function automatic exp_t mk(input logic [14:0] s, input logic h, input logic c, input logic [2:0] t);
        exp_t e;
        e.strb = s; e.halt = h; e.chk_step = c; e.step = t;
        return e;
    endfunction

    task automatic drive_cycle(input logic rst, input logic [3:0] op, input logic z, input logic c,
                               input logic n, input exp_t e);
        @(negedge clk);
        reset  = rst;
        opcode = op;
        fz = z; fc = c; fn = n;
        exp_q.push_back(e);
    endtask

    // Reference: an instruction is the two-cycle fetch followed by its execute micro-ops,
    // padded with idle cycles to the instruction length.
    task automatic run_instr(input logic [3:0] op, input logic z, input logic c, input logic n,
                             input int abort_at);
        logic [14:0] seq[$];
        logic [14:0] ex[$];
        bit taken;
        taken = (op == 4'h6) || (op == 4'h7 && c) || (op == 4'h8 && z) || (op == 4'h9 && n);
        case (op)
            4'h1: ex = '{IR_OE | MAR_LD, RAM_OE | A_LD | FL_LD};
            4'h2: ex = '{IR_OE | MAR_LD, RAM_OE | B_LD, ALU_OE | A_LD | FL_LD};
            4'h3: ex = '{IR_OE | MAR_LD, RAM_OE | B_LD | ALU_SUB, ALU_OE | A_LD | FL_LD | ALU_SUB};
            4'h4: ex = '{IR_OE | MAR_LD, A_OE | RAM_WE};
            4'h5: ex = '{IR_OE | A_LD | FL_LD};
            4'h6, 4'h7, 4'h8, 4'h9: ex = '{taken ? (IR_OE | PC_LD) : 15'd0};
            4'hE: ex = '{A_OE | O_LD};
            default: ex = '{15'd0};
        endcase
        seq = '{PC_OE | MAR_LD, RAM_OE | IR_LD | PC_INC};
        foreach (ex[i]) seq.push_back(ex[i]);
`ifndef VARIABLE_LENGTH_EN
        if (op != 4'hF) while (seq.size() < 7) seq.push_back(15'd0);
`endif
        $display("instr op=%h z=%0b c=%0b n=%0b cycles=%0d abort_at=%0d", op, z, c, n, seq.size(), abort_at);
        for (int t = 0; t < seq.size(); t++) begin
            if (t == abort_at) begin
                drive_cycle(1'b0, op, z, c, n, mk(15'd0, 1'b0, 1'b1, 3'd0));
                drive_cycle(1'b1, op, z, c, n, mk(15'd0, 1'b0, 1'b1, 3'd0));
                return;
            end
            // Opcode is only guaranteed from T2; earlier cycles see junk to prove fetch ignores it.
            if (t < 2)
                drive_cycle(1'b1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                            mk(seq[t], 1'b0, 1'b1, 3'(t)));
            else
                drive_cycle(1'b1, op, z, c, n, mk(seq[t], 1'b0, 1'b1, 3'(t)));
        end
    endtask

    task automatic halt_idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            drive_cycle(1'b1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                        mk(15'd0, 1'b1, 1'b0, 3'd0));
    endtask

    task automatic rand_instr();
        run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), 1'($urandom), -1);
    endtask

    // Monitor: one expected record per cycle, checked mid-cycle.
    initial begin : monitor
        exp_t e;
        logic       prev_halt;
        logic [2:0] halt_step;
        prev_halt = 1'b0;
        halt_step = 3'd0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act_strb !== e.strb) begin
                    errors++;
                    $display("FAIL strobes t=%0t got=%h want=%h", $time, act_strb, e.strb);
                end
                checks++;
                if (halt !== e.halt) begin
                    errors++;
                    $display("FAIL halt t=%0t got=%b want=%b", $time, halt, e.halt);
                end
                checks++;
                if ($countones(act_strb & OE_MASK) > 1) begin
                    errors++;
                    $display("FAIL oe_onehot t=%0t got=%h want<=1 driver", $time, act_strb & OE_MASK);
                end
                if (e.chk_step) begin
                    checks++;
                    if (step !== e.step) begin
                        errors++;
                        $display("FAIL step t=%0t got=%0d want=%0d", $time, step, e.step);
                    end
                end else if (e.halt && prev_halt) begin
                    checks++;
                    if (step !== halt_step) begin
                        errors++;
                        $display("FAIL halt_step t=%0t got=%0d want=%0d", $time, step, halt_step);
                    end
                end
                if (e.halt && !prev_halt) halt_step = step;
                prev_halt = e.halt;
            end
        end
    end

    initial begin : driver
        #1 reset = 1'b0;
        drive_cycle(1'b0, 4'h2, 1'b1, 1'b1, 1'b1, mk(15'd0, 1'b0, 1'b1, 3'd0));
        drive_cycle(1'b0, 4'h6, 1'b1, 1'b1, 1'b1, mk(15'd0, 1'b0, 1'b1, 3'd0));
        drive_cycle(1'b1, 4'h6, 1'b1, 1'b1, 1'b1, mk(15'd0, 1'b0, 1'b1, 3'd0));  // INIT cycle
        // Directed: every opcode class, both branches of each conditional jump.
        run_instr(4'h5, 1'b1, 1'b0, 1'b0, -1);
        run_instr(4'h8, 1'b1, 1'b0, 1'b0, -1);
        run_instr(4'h8, 1'b0, 1'b1, 1'b1, -1);
        run_instr(4'h7, 1'b0, 1'b1, 1'b0, -1);
        run_instr(4'h7, 1'b1, 1'b0, 1'b1, -1);
        run_instr(4'h9, 1'b0, 1'b0, 1'b1, -1);
        run_instr(4'h9, 1'b1, 1'b1, 1'b0, -1);
        run_instr(4'h2, 1'b0, 1'b0, 1'b0, -1);
        run_instr(4'h3, 1'b0, 1'b0, 1'b0, -1);
        run_instr(4'h1, 1'b0, 1'b0, 1'b0, -1);
        run_instr(4'h4, 1'b0, 1'b0, 1'b0, -1);
        run_instr(4'h6, 1'b0, 1'b0, 1'b0, -1);
        run_instr(4'hE, 1'b0, 1'b0, 1'b0, -1);
        run_instr(4'h0, 1'b1, 1'b1, 1'b1, -1);
        run_instr(4'hB, 1'b1, 1'b1, 1'b1, -1);
        for (int i = 0; i < 30; i++) rand_instr();
        // Reset at T3 of ADD, then resume from a clean fetch.
        run_instr(4'h2, 1'b0, 1'b0, 1'b0, 3);
        run_instr(4'h5, 1'b0, 1'b0, 1'b0, -1);
        run_instr(4'h2, 1'b0, 1'b0, 1'b0, -1);
        run_instr(4'hF, 1'b0, 1'b0, 1'b0, -1);
        halt_idle(20);
        drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, mk(15'd0, 1'b0, 1'b1, 3'd0));
        drive_cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, mk(15'd0, 1'b0, 1'b1, 3'd0));
        for (int i = 0; i < 10; i++) rand_instr();
        run_instr(4'hF, 1'b1, 1'b1, 1'b1, -1);
        halt_idle(3);
        driver_done = 1'b1;
    end

    initial begin : finisher
        wait (driver_done);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #5;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
